// File: rtl/fpgapu_pkg.sv
// rtl/fpgapu_pkg.sv - shared ROM geometry, channel count and ROM word field layouts
package fpgapu_pkg;

    // Pattern/order ROM geometry
    localparam int ROM_ADDR_W     = 8;
    localparam int ROM_DATA_W     = 16;

    // Number of sequencer voices sharing the ROM by default
    localparam int DEFAULT_NUM_CH = 4;

    // Order-word fields
    localparam int ORD_PITCH_LSB  = 0;
    localparam int ORD_PITCH_W    = 6;
    localparam int ORD_LEN_LSB    = 6;
    localparam int ORD_LEN_W      = 5;
    localparam int ORD_INSTR_LSB  = 11;
    localparam int ORD_INSTR_W    = 4;

    // Pattern-word fields
    localparam int PAT_ADDR_LSB   = 0;
    localparam int PAT_ADDR_W     = 8;
    localparam int PAT_LEN_LSB    = 8;
    localparam int PAT_LEN_W      = 8;

    typedef struct packed {
        logic                   spare;
        logic [ORD_INSTR_W-1:0] instrument;
        logic [ORD_LEN_W-1:0]   length;
        logic [ORD_PITCH_W-1:0] pitch;
    } order_word_t;

    typedef struct packed {
        logic [PAT_LEN_W-1:0]  pat_len;
        logic [PAT_ADDR_W-1:0] pat_addr;
    } pattern_word_t;

    function automatic logic [ORD_PITCH_W-1:0] order_pitch(input logic [ROM_DATA_W-1:0] w);
        return w[ORD_PITCH_LSB +: ORD_PITCH_W];
    endfunction

    function automatic logic [PAT_ADDR_W-1:0] pattern_addr(input logic [ROM_DATA_W-1:0] w);
        return w[PAT_ADDR_LSB +: PAT_ADDR_W];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector starting after the last grant
module rr_pick
    import fpgapu_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_gnt,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    logic [IDX_W-1:0] k;

    // Walk from last_gnt+1 around the ring; the first requester found wins
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            k = IDX_W'((int'(last_gnt) + i) % NUM_CH);
            if (!any && req[k]) begin
                gnt[k] = 1'b1;
                idx    = k;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin sharing of one synchronous ROM port between sequencer channels
module rom_arbiter
    import fpgapu_pkg::*;
#(
    parameter int NUM_CH      = DEFAULT_NUM_CH,
    parameter int ADDR_W      = ROM_ADDR_W,
    parameter int DATA_W      = ROM_DATA_W,
    parameter int ROM_LATENCY = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_enable,
    input  logic [NUM_CH-1:0]        i_req,
    input  logic [NUM_CH*ADDR_W-1:0] i_addr,
    output logic [NUM_CH-1:0]        o_gnt,
    output logic [NUM_CH-1:0]        o_rvalid,
    output logic [DATA_W-1:0]        o_rdata,
    output logic                     o_busy,
    output logic [ADDR_W-1:0]        o_rom_addr,
    input  logic [DATA_W-1:0]        i_rom_data
);

    localparam int               IDX_W    = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CH - 1);

    logic [NUM_CH-1:0] cand;
    logic [NUM_CH-1:0] pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [IDX_W-1:0]  last_gnt;
    logic [ADDR_W-1:0] addr_sel;
    logic [ADDR_W-1:0] rom_addr_q;

    // Stage 0 travels alongside o_rom_addr; stages 1..ROM_LATENCY cover the ROM read
    logic [NUM_CH-1:0] tag_q [0:ROM_LATENCY];

    // Grants are suppressed while disabled and while reset is asserted
    assign cand = i_req & {NUM_CH{i_enable}} & {NUM_CH{i_rst_n}};

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_pick (
        .req      (cand),
        .last_gnt (last_gnt),
        .gnt      (pick_gnt),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    assign o_gnt      = pick_gnt;
    assign o_rom_addr = rom_addr_q;
    assign o_rvalid   = tag_q[ROM_LATENCY];
    assign o_rdata    = i_rom_data;

    // One-hot address mux; yields zero when nobody is granted
    always_comb begin
        addr_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pick_gnt[c]) begin
                addr_sel = addr_sel | i_addr[c*ADDR_W +: ADDR_W];
            end
        end
    end

    // Remember the most recent winner so it drops to lowest priority
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_gnt <= LAST_RST;
        end else if (pick_any) begin
            last_gnt <= pick_idx;
        end
    end

    // Register the winner's address toward the ROM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rom_addr_q <= '0;
        end else begin
            rom_addr_q <= addr_sel;
        end
    end

    // Carry the winner tag down the read pipeline so data returns to the right channel
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s <= ROM_LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= pick_gnt;
            for (int s = 1; s <= ROM_LATENCY; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    // Busy while any pipeline stage holds a read
    always_comb begin
        o_busy = 1'b0;
        for (int s = 0; s <= ROM_LATENCY; s++) begin
            o_busy = o_busy | (|tag_q[s]);
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - scoreboard bench for rom_arbiter at ROM latency 1 and 3
module tb_rom_arbiter;

    localparam logic [7:0] A0 = 8'h04;
    localparam logic [7:0] A1 = 8'h22;
    localparam logic [7:0] A2 = 8'h15;
    localparam logic [7:0] A3 = 8'h37;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;

    logic        en_a, busy_a;
    logic [3:0]  req_a, gnt_a, rvalid_a;
    logic [15:0] rdata_a, rom_a;
    logic [7:0]  romaddr_a;

    logic        en_b, busy_b;
    logic [3:0]  req_b, gnt_b, rvalid_b;
    logic [15:0] rdata_b, rb1, rb2, rb3;
    logic [7:0]  romaddr_b;

    typedef struct {
        int          ch;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    rom_arbiter #(.NUM_CH(4), .ADDR_W(8), .DATA_W(16), .ROM_LATENCY(1)) u_dut_a (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_enable   (en_a),
        .i_req      (req_a),
        .i_addr     (addr),
        .o_gnt      (gnt_a),
        .o_rvalid   (rvalid_a),
        .o_rdata    (rdata_a),
        .o_busy     (busy_a),
        .o_rom_addr (romaddr_a),
        .i_rom_data (rom_a)
    );

    rom_arbiter #(.NUM_CH(4), .ADDR_W(8), .DATA_W(16), .ROM_LATENCY(3)) u_dut_b (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_enable   (en_b),
        .i_req      (req_b),
        .i_addr     (addr),
        .o_gnt      (gnt_b),
        .o_rvalid   (rvalid_b),
        .o_rdata    (rdata_b),
        .o_busy     (busy_b),
        .o_rom_addr (romaddr_b),
        .i_rom_data (rb3)
    );

    function automatic logic [15:0] rom_f(input logic [7:0] a);
        return {a ^ 8'hA5, ~a};
    endfunction

    function automatic logic [7:0] addr_of(input int ch);
        case (ch)
            0:       return A0;
            1:       return A1;
            2:       return A2;
            default: return A3;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) rom_a <= rom_f(romaddr_a);

    always @(posedge clk) begin
        rb1 <= rom_f(romaddr_b);
        rb2 <= rb1;
        rb3 <= rb2;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_e = sb.pop_front();
                n_cmp++;
                if (rvalid_a !== 4'(1 << mon_e.ch) || rdata_a !== mon_e.data || mon_e.due != cyc) begin
                    n_fail++;
                    $display("FAIL rvalid_a cyc %0d: got rvalid=%b rdata=%h, expected rvalid=%b rdata=%h due %0d",
                             cyc, rvalid_a, rdata_a, 4'(1 << mon_e.ch), mon_e.data, mon_e.due);
                end
            end else begin
                n_cmp++;
                if (rvalid_a !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL idle_rvalid_a cyc %0d: got rvalid=%b, expected 0000", cyc, rvalid_a);
                end
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        en_a  = 1'b1;
        en_b  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en_a  = 1'b1;
        req_a = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (gnt_a !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b, expected 0000", gnt_a); end
        n_cmp++; if (rvalid_a !== 4'b0000) begin n_fail++; $display("FAIL reset_rvalid: got %b, expected 0000", rvalid_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy_a); end
        n_cmp++; if (romaddr_a !== 8'h00) begin n_fail++; $display("FAIL reset_rom_addr: got %h, expected 00", romaddr_a); end
        req_a = '0;
    endtask

    task automatic test_single;
        req_a = 4'b0100;
        @(negedge clk);
        n_cmp++; if (gnt_a !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b, expected 0100", gnt_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL single_busy_c0: got %b, expected 0", busy_a); end
        sb.push_back('{2, rom_f(A2), cyc + 2});
        next_cycle();
        req_a = 4'b0000;
        @(negedge clk);
        n_cmp++; if (romaddr_a !== A2) begin n_fail++; $display("FAIL single_rom_addr: got %h, expected %h", romaddr_a, A2); end
        n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy_c1: got %b, expected 1", busy_a); end
        n_cmp++; if (gnt_a !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_c1: got %b, expected 0000", gnt_a); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy_c2: got %b, expected 1", busy_a); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL single_busy_c3: got %b, expected 0", busy_a); end
        next_cycle();
    endtask

    task automatic test_all_four;
        int prev = -1;
        for (int t = 0; t < 8; t++) begin
            int ch = t % 4;
            req_a = 4'b1111;
            @(negedge clk);
            n_cmp++;
            if (gnt_a !== 4'(1 << ch)) begin
                n_fail++; $display("FAIL all_four_gnt t=%0d: got %b, expected %b", t, gnt_a, 4'(1 << ch));
            end
            if (prev >= 0) begin
                n_cmp++;
                if (romaddr_a !== addr_of(prev)) begin
                    n_fail++; $display("FAIL all_four_rom_addr t=%0d: got %h, expected %h", t, romaddr_a, addr_of(prev));
                end
            end
            sb.push_back('{ch, rom_f(addr_of(ch)), cyc + 2});
            prev = ch;
            next_cycle();
        end
        req_a = 4'b0000;
        repeat (3) next_cycle();
    endtask

    task automatic test_alternate;
        int seq [6] = '{1, 3, 1, 3, 1, 3};
        req_a = 4'b1000;
        @(negedge clk);
        n_cmp++; if (gnt_a !== 4'b1000) begin n_fail++; $display("FAIL alt_first_gnt: got %b, expected 1000", gnt_a); end
        sb.push_back('{3, rom_f(A3), cyc + 2});
        next_cycle();
        for (int t = 0; t < 6; t++) begin
            req_a = 4'b1010;
            @(negedge clk);
            n_cmp++;
            if (gnt_a !== 4'(1 << seq[t])) begin
                n_fail++; $display("FAIL alt_gnt t=%0d: got %b, expected %b", t, gnt_a, 4'(1 << seq[t]));
            end
            sb.push_back('{seq[t], rom_f(addr_of(seq[t])), cyc + 2});
            next_cycle();
        end
        req_a = 4'b0000;
        repeat (3) next_cycle();
    endtask

    task automatic test_enable;
        req_a = 4'b0001;
        en_a  = 1'b1;
        @(negedge clk);
        n_cmp++; if (gnt_a !== 4'b0001) begin n_fail++; $display("FAIL en_first_gnt: got %b, expected 0001", gnt_a); end
        sb.push_back('{0, rom_f(A0), cyc + 2});
        next_cycle();
        for (int t = 0; t < 3; t++) begin
            en_a  = 1'b0;
            req_a = 4'b1111;
            @(negedge clk);
            n_cmp++;
            if (gnt_a !== 4'b0000) begin n_fail++; $display("FAIL en_off_gnt t=%0d: got %b, expected 0000", t, gnt_a); end
            if (t == 0) begin
                n_cmp++;
                if (romaddr_a !== A0) begin n_fail++; $display("FAIL en_off_rom_addr: got %h, expected %h", romaddr_a, A0); end
            end
            next_cycle();
        end
        en_a  = 1'b1;
        req_a = 4'b1011;
        @(negedge clk);
        n_cmp++; if (gnt_a !== 4'b0010) begin n_fail++; $display("FAIL en_resume_gnt: got %b, expected 0010", gnt_a); end
        sb.push_back('{1, rom_f(A1), cyc + 2});
        next_cycle();
        req_a = 4'b0000;
        repeat (3) next_cycle();
    endtask

    task automatic test_reset_mid;
        req_a = 4'b0001;
        @(negedge clk);
        n_cmp++; if (gnt_a !== 4'b0001) begin n_fail++; $display("FAIL rmid_gnt: got %b, expected 0001", gnt_a); end
        next_cycle();
        req_a = 4'b1111;
        #2;
        n_cmp++; if (gnt_a !== 4'b0010) begin n_fail++; $display("FAIL rmid_pre_gnt: got %b, expected 0010", gnt_a); end
        n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_busy: got %b, expected 1", busy_a); end
        n_cmp++; if (romaddr_a !== A0) begin n_fail++; $display("FAIL rmid_pre_rom_addr: got %h, expected %h", romaddr_a, A0); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (gnt_a !== 4'b0000) begin n_fail++; $display("FAIL rmid_async_gnt: got %b, expected 0000", gnt_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rmid_async_busy: got %b, expected 0", busy_a); end
        n_cmp++; if (romaddr_a !== 8'h00) begin n_fail++; $display("FAIL rmid_async_rom_addr: got %h, expected 00", romaddr_a); end
        n_cmp++; if (rvalid_a !== 4'b0000) begin n_fail++; $display("FAIL rmid_async_rvalid: got %b, expected 0000", rvalid_a); end
        next_cycle();
        rst_n = 1'b1;
        req_a = 4'b1111;
        @(negedge clk);
        n_cmp++; if (gnt_a !== 4'b0001) begin n_fail++; $display("FAIL rmid_release_gnt: got %b, expected 0001", gnt_a); end
        sb.push_back('{0, rom_f(A0), cyc + 2});
        next_cycle();
        req_a = 4'b0000;
        repeat (3) next_cycle();
    endtask

    task automatic test_latency3;
        logic [3:0] rq [9] = '{4'b0111, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] eg [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] ev [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
        for (int t = 0; t < 9; t++) begin
            req_b = rq[t];
            @(negedge clk);
            n_cmp++;
            if (gnt_b !== eg[t]) begin n_fail++; $display("FAIL lat3_gnt t=%0d: got %b, expected %b", t, gnt_b, eg[t]); end
            n_cmp++;
            if (rvalid_b !== ev[t]) begin n_fail++; $display("FAIL lat3_rvalid t=%0d: got %b, expected %b", t, rvalid_b, ev[t]); end
            if (t >= 4 && t <= 6) begin
                n_cmp++;
                if (rdata_b !== rom_f(addr_of(t - 4))) begin
                    n_fail++; $display("FAIL lat3_rdata t=%0d: got %h, expected %h", t, rdata_b, rom_f(addr_of(t - 4)));
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        addr  = {A3, A2, A1, A0};
        rst_n = 1'b0;
        en_a  = 1'b1;
        en_b  = 1'b1;
        req_a = '0;
        req_b = '0;
        test_reset();
        do_reset();
        mon_en = 1'b1;
        test_single();
        do_reset();
        test_all_four();
        do_reset();
        test_alternate();
        do_reset();
        test_enable();
        do_reset();
        test_reset_mid();
        do_reset();
        test_latency3();
        repeat (2) next_cycle();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
